pmem_burst_responder: RTL and testbench

PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

---
 rtl/pmem_pkg.sv | 32 +++
 rtl/pmem_line_store.sv | 38 +++
 rtl/pmem_burst_responder.sv | 123 ++++++++++++
 tb/tb_pmem_burst_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the
// pseudo-memory burst responder.
package pmem_pkg;

  localparam int BEAT_W     = 64;
  localparam int BEATS      = 4;
  localparam int LINE_W     = 256;
  localparam int BE_W       = 8;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } pmem_state_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [BEAT_W-1:0] be_merge(
    input logic [BEAT_W-1:0] old_beat,
    input logic [BEAT_W-1:0] new_beat,
    input logic [BE_W-1:0]   be
  );
    logic [BEAT_W-1:0] res;
    res = old_beat;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_beat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pmem_line_store.sv
// Line storage: DEPTH_LINES lines of four 64-bit beats. Synchronous
// byte-enabled beat write, combinational indexed beat read. Contents are
// deliberately not touched by reset.
module pmem_line_store
  import pmem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_widx,
  input  logic [BEAT_IDX_W-1:0] i_wbeat,
  input  logic [BEAT_W-1:0]     i_wdata,
  input  logic [BE_W-1:0]       i_wbe,
  input  logic [IDX_W-1:0]      i_ridx,
  input  logic [BEAT_IDX_W-1:0] i_rbeat,
  output logic [BEAT_W-1:0]     o_rdata
);

  logic [BEAT_W-1:0] r_mem [DEPTH_LINES*BEATS];

  logic [IDX_W+BEAT_IDX_W-1:0] w_waddr;
  logic [IDX_W+BEAT_IDX_W-1:0] w_raddr;

  assign w_waddr = {i_widx, i_wbeat};
  assign w_raddr = {i_ridx, i_rbeat};

  // Merge the enabled byte lanes of the incoming beat into the stored beat.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_waddr] <= be_merge(r_mem[w_waddr], i_wdata, i_wbe);
    end
  end

  assign o_rdata = r_mem[w_raddr];

endmodule

// File: rtl/pmem_burst_responder.sv
// Pseudo-memory burst responder: accepts a one-line read or write request,
// waits LATENCY cycles, then streams four 64-bit beats with mem_resp high,
// followed by one idle DONE cycle. The beat registered out of BURST appears
// on mem_resp/mem_rdata one edge later, so BURST is entered one edge before
// the first response beat.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_byte_enable,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        protocol_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  // WAIT holds LATENCY-1 cycles: counter value LATENCY-2 down to 0.
  localparam logic [3:0] LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  pmem_state_t             r_state;
  logic [3:0]              r_cnt;
  logic [BEAT_IDX_W-1:0]   r_beat;
  logic [BEAT_IDX_W-1:0]   r_obeat;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_is_wr;
  logic                    r_resp;
  logic [BEAT_W-1:0]       r_rdata;
  logic                    r_perr;

  logic [IDX_W-1:0]        w_idx;
  logic                    w_req;
  logic                    w_we;
  logic [BEAT_W-1:0]       w_rd_beat;
  logic                    w_unused_addr;

  assign w_idx = mem_address[5 +: IDX_W];
  assign w_req = mem_read | mem_write;
  // A write beat is committed at the edge that ends its mem_resp-high cycle.
  assign w_we  = r_resp & r_is_wr;
  // Offset bits and bits above the index have no function.
  assign w_unused_addr = ^{mem_address[4:0], mem_address >> (5 + IDX_W)};

  pmem_line_store #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wbeat (r_obeat),
    .i_wdata (mem_wdata),
    .i_wbe   (mem_byte_enable),
    .i_ridx  (r_idx),
    .i_rbeat (r_beat),
    .o_rdata (w_rd_beat)
  );

  // Transaction FSM with registered beat strobe, read data and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_beat  <= '0;
      r_obeat <= '0;
      r_idx   <= '0;
      r_is_wr <= 1'b0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_idx;
            // A simultaneous read+write is served as a read only.
            r_is_wr <= mem_write & ~mem_read;
            r_beat  <= '0;
            if (mem_read && mem_write) r_perr <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= BURST;
            end else begin
              r_cnt   <= LAT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= BURST;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        BURST: begin
          r_resp  <= 1'b1;
          r_obeat <= r_beat;
          r_rdata <= r_is_wr ? '0 : w_rd_beat;
          r_beat  <= r_beat + 2'd1;
          if (r_beat == 2'd3) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_resp     = r_resp;
  assign mem_rdata    = r_rdata;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder: a LATENCY=4 instance checked every
// cycle against a timeline/memory model, plus a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_pmem_burst_responder;

  localparam int LAT = 4;

  typedef logic [63:0] beats_t [4];
  typedef logic [7:0]  bes_t   [4];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_byte_enable;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        protocol_err;

  logic [31:0] mem_address_l1;
  logic        mem_read_l1;
  logic        mem_write_l1;
  logic [63:0] mem_wdata_l1;
  logic [7:0]  mem_byte_enable_l1;
  logic [63:0] mem_rdata_l1;
  logic        mem_resp_l1;
  logic        protocol_err_l1;

  always #5 clk = ~clk;

  pmem_burst_responder #(.LATENCY(LAT), .DEPTH_LINES(256)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .protocol_err(protocol_err)
  );

  pmem_burst_responder #(.LATENCY(1), .DEPTH_LINES(256)) dut_l1 (
    .clk(clk), .rst(rst), .mem_address(mem_address_l1), .mem_read(mem_read_l1),
    .mem_write(mem_write_l1), .mem_wdata(mem_wdata_l1), .mem_byte_enable(mem_byte_enable_l1),
    .mem_rdata(mem_rdata_l1), .mem_resp(mem_resp_l1), .protocol_err(protocol_err_l1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected outputs indexed by the number of the edge that starts the cycle.
  bit          sched_resp  [0:1023];
  logic [63:0] sched_rdata [0:1023];
  bit          exp_perr = 1'b0;
  bit          chk_en   = 1'b0;
  logic [63:0] mdl [0:255][0:3];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("resp",  64'(mem_resp),     64'(sched_resp[cyc]));
      chk("rdata", mem_rdata,         sched_rdata[cyc]);
      chk("perr",  64'(protocol_err), 64'(exp_perr));
    end
  end

  // Called #1 after an edge; the request is captured at the next edge E.
  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                      input beats_t wd, input bes_t be, input bit abuse, input int rst_beat,
                      output beats_t got, output int first, output int n);
    int E;
    int idx;
    int kk;
    E = cyc + 1;
    idx = int'(addr[12:5]);
    first = -1;
    n = 0;
    got = '{default: 64'd0};
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_wdata = wd[0]; mem_byte_enable = be[0];
    for (int k = 0; k < 4; k++) begin
      sched_resp[E+LAT+k]  = 1'b1;
      sched_rdata[E+LAT+k] = rd ? mdl[idx][k] : 64'd0;
    end
    for (int e = E; e <= E + LAT + 4; e++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        n++;
        if (first < 0) first = e - E;
      end
      if (e >= E + LAT && e <= E + LAT + 3) got[e-E-LAT] = mem_rdata;
      if (e == E && rd && wr) exp_perr = 1'b1;
      if (abuse && e == E + LAT + 2) begin
        mem_read = 1'b0;
        mem_address = 32'h0000_1000;
      end
      if (wr && !rd && e >= E + LAT + 1) begin
        kk = e - E - LAT - 1;
        mdl[idx][kk] = merge(mdl[idx][kk], wd[kk], be[kk]);
        if (kk < 3) begin
          mem_wdata = wd[kk+1];
          mem_byte_enable = be[kk+1];
        end
      end
      if (rst_beat >= 0 && e == E + LAT + rst_beat) begin
        rst = 1'b1;
        for (int c = e; c <= e + 8; c++) begin
          sched_resp[c] = 1'b0;
          sched_rdata[c] = 64'd0;
        end
        exp_perr = 1'b0;
        #1;
        chk("rst_async_resp",  64'(mem_resp), 64'd0);
        chk("rst_async_rdata", mem_rdata,     64'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic xact1(input bit rd, input logic [31:0] addr, input beats_t wd,
                       output beats_t got, output int first, output int n);
    int E;
    E = cyc + 1;
    first = -1;
    n = 0;
    got = '{default: 64'd0};
    mem_address_l1 = addr; mem_read_l1 = rd; mem_write_l1 = !rd;
    mem_wdata_l1 = wd[0]; mem_byte_enable_l1 = 8'hFF;
    for (int e = E; e <= E + 5; e++) begin
      @(posedge clk); #1;
      if (mem_resp_l1) begin
        n++;
        if (first < 0) first = e - E;
      end
      if (e >= E + 1 && e <= E + 4) got[e-E-1] = mem_rdata_l1;
      if (!rd && e >= E + 2 && e <= E + 4) mem_wdata_l1 = wd[e-E-1];
    end
    mem_read_l1 = 1'b0;
    mem_write_l1 = 1'b0;
  endtask

  beats_t w1, w2, w3, w4, wpart, wbad, wz, got;
  bes_t   be_ff, be_part;
  int     first, n;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sched_resp[i] = 1'b0;
      sched_rdata[i] = 64'd0;
    end
    w1    = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    w2    = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    w3    = '{64'hC1C1_C1C1_C1C1_C1C1, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3, 64'hC4C4_C4C4_C4C4_C4C4};
    w4    = '{64'hF0F0_0000_0000_F0F0, 64'hF1F1_0000_0000_F1F1, 64'hF2F2_0000_0000_F2F2, 64'hF3F3_0000_0000_F3F3};
    wpart = '{64'h0, 64'h0, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0};
    wbad  = '{default: 64'hDEAD_BEEF_DEAD_BEEF};
    wz    = '{default: 64'h0};
    be_ff   = '{default: 8'hFF};
    be_part = '{8'h00, 8'h00, 8'h0F, 8'h00};

    rst = 1'b1;
    mem_address = '0; mem_read = 0; mem_write = 0; mem_wdata = '0; mem_byte_enable = '0;
    mem_address_l1 = '0; mem_read_l1 = 0; mem_write_l1 = 0; mem_wdata_l1 = '0; mem_byte_enable_l1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp",     64'(mem_resp),        64'd0);
    chk("reset_rdata",    mem_rdata,            64'd0);
    chk("reset_perr",     64'(protocol_err),    64'd0);
    chk("reset_resp_l1",  64'(mem_resp_l1),     64'd0);
    chk("reset_perr_l1",  64'(protocol_err_l1), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Full-line write then readback.
    xact(1'b0, 1'b1, 32'h0000_0040, w1, be_ff, 1'b0, -1, got, first, n);
    chk("wr_first_resp_lat", 64'(first), 64'd4);
    chk("wr_resp_beats",     64'(n),     64'd4);
    xact(1'b1, 1'b0, 32'h0000_0040, wz, be_ff, 1'b0, -1, got, first, n);
    chk("rd_first_resp_lat", 64'(first), 64'd4);
    chk("rd_beat0", got[0], 64'h1111_1111_1111_1111);
    chk("rd_beat1", got[1], 64'h2222_2222_2222_2222);
    chk("rd_beat2", got[2], 64'h3333_3333_3333_3333);
    chk("rd_beat3", got[3], 64'h4444_4444_4444_4444);

    // Partial byte-enable write over beat 2.
    xact(1'b0, 1'b1, 32'h0000_0040, wpart, be_part, 1'b0, -1, got, first, n);
    xact(1'b1, 1'b0, 32'h0000_0040, wz, be_ff, 1'b0, -1, got, first, n);
    chk("part_beat2", got[2], 64'h3333_3333_BBBB_BBBB);
    chk("part_beat0", got[0], 64'h1111_1111_1111_1111);
    chk("part_beat3", got[3], 64'h4444_4444_4444_4444);

    // Simultaneous read+write: read wins, error flag sticks.
    xact(1'b1, 1'b1, 32'h0000_0040, wbad, be_ff, 1'b0, -1, got, first, n);
    chk("sim_beat1", got[1], 64'h2222_2222_2222_2222);
    chk("sim_perr",  64'(protocol_err), 64'd1);
    xact(1'b1, 1'b0, 32'h0000_0040, wz, be_ff, 1'b0, -1, got, first, n);
    chk("sim_unchanged0", got[0], 64'h1111_1111_1111_1111);
    chk("sim_unchanged2", got[2], 64'h3333_3333_BBBB_BBBB);
    chk("sim_perr_sticky", 64'(protocol_err), 64'd1);

    // Mid-burst abuse, then a back-to-back write.
    xact(1'b1, 1'b0, 32'h0000_0040, wz, be_ff, 1'b1, -1, got, first, n);
    chk("abuse_beats", 64'(n), 64'd4);
    chk("abuse_beat0", got[0], 64'h1111_1111_1111_1111);
    chk("abuse_beat2", got[2], 64'h3333_3333_BBBB_BBBB);
    chk("abuse_beat3", got[3], 64'h4444_4444_4444_4444);
    xact(1'b0, 1'b1, 32'h0000_0080, w2, be_ff, 1'b0, -1, got, first, n);
    chk("b2b_first_resp_lat", 64'(first), 64'd4);
    chk("b2b_resp_beats",     64'(n),     64'd4);
    xact(1'b1, 1'b0, 32'h0000_0080, wz, be_ff, 1'b0, -1, got, first, n);
    chk("b2b_beat3", got[3], 64'h8888_8888_8888_8888);

    // Reset during write beat 2.
    xact(1'b0, 1'b1, 32'h0000_0080, w3, be_ff, 1'b0, 2, got, first, n);
    chk("rst_perr_clear", 64'(protocol_err), 64'd0);
    xact(1'b1, 1'b0, 32'h0000_0080, wz, be_ff, 1'b0, -1, got, first, n);
    chk("rst_beat0", got[0], 64'hC1C1_C1C1_C1C1_C1C1);
    chk("rst_beat1", got[1], 64'hC2C2_C2C2_C2C2_C2C2);
    chk("rst_beat2", got[2], 64'h7777_7777_7777_7777);
    chk("rst_beat3", got[3], 64'h8888_8888_8888_8888);

    // LATENCY=1 instance.
    xact1(1'b0, 32'h0000_00C0, w4, got, first, n);
    chk("l1_wr_first", 64'(first), 64'd1);
    chk("l1_wr_beats", 64'(n),     64'd4);
    xact1(1'b1, 32'h0000_00C0, wz, got, first, n);
    chk("l1_rd_first", 64'(first), 64'd1);
    chk("l1_rd_beats", 64'(n),     64'd4);
    chk("l1_beat0", got[0], 64'hF0F0_0000_0000_F0F0);
    chk("l1_beat1", got[1], 64'hF1F1_0000_0000_F1F1);
    chk("l1_beat2", got[2], 64'hF2F2_0000_0000_F2F2);
    chk("l1_beat3", got[3], 64'hF3F3_0000_0000_F3F3);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
